// File: rtl/fft_engine_seq_if.sv
// Butterfly command bus between the FFT sequencer (master) and the butterfly datapath (slave).
interface fft_engine_seq_if #(
  parameter int FFT_MAX_LENGTH_LOG2 = 12
);
  localparam int AW = FFT_MAX_LENGTH_LOG2;
  localparam int SW = $clog2(FFT_MAX_LENGTH_LOG2) + 1;

  logic          bf_valid_o;
  logic          bf_ready_i;
  logic [SW-1:0] bf_stage_o;
  logic [AW-1:0] bf_addr_a_o;
  logic [AW-1:0] bf_addr_b_o;
  logic [AW-2:0] bf_tw_addr_o;
  logic          bf_last_o;
  logic          dp_overflow_i;

  modport master (
    output bf_valid_o, bf_stage_o, bf_addr_a_o, bf_addr_b_o, bf_tw_addr_o, bf_last_o,
    input  bf_ready_i, dp_overflow_i
  );

  modport slave (
    input  bf_valid_o, bf_stage_o, bf_addr_a_o, bf_addr_b_o, bf_tw_addr_o, bf_last_o,
    output bf_ready_i, dp_overflow_i
  );
endinterface

// File: rtl/fft_engine_seq.sv
// Radix-2 DIT butterfly sequencer: walks every stage of an in-place FFT, one command per
// valid/ready beat, with a pipeline-drain gap between stages and done/error/overflow reporting.
module fft_engine_seq #(
  parameter int FFT_MAX_LENGTH_LOG2 = 12,
  parameter int PIPE_DEPTH          = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  fft_start_i,
  input  logic                  fft_reset_i,
  input  logic [11:0]           fft_length_log2_i,
  output logic                  fft_busy_o,
  output logic                  fft_done_o,
  output logic                  fft_error_o,
  output logic                  overflow_detect_o,
  fft_engine_seq_if.master      bf
);

  localparam int AW = FFT_MAX_LENGTH_LOG2;
  localparam int SW = $clog2(FFT_MAX_LENGTH_LOG2) + 1;
  localparam int KW = AW - 1;
  localparam logic [11:0] MAX_L    = 12'(FFT_MAX_LENGTH_LOG2);
  localparam logic [3:0]  GAP_LAST = 4'(PIPE_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RUN,
    GAP,
    DONE,
    ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   len_q, len_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    gap_q, gap_d;
  logic          ovf_q, ovf_d;

  logic          run;
  logic [AW-1:0] half, pos, grp, addr_a;
  logic [11:0]   tw_shift;
  logic [KW-1:0] k_last;
  logic          last_k, last_s;

  // Address generation depends only on registered s/k/L, so commands hold during stalls.
  always_comb begin
    half     = AW'(1) << s_q;
    pos      = {1'b0, k_q} & (half - AW'(1));
    grp      = {1'b0, k_q} >> s_q;
    addr_a   = (grp << (s_q + SW'(1))) | pos;
    tw_shift = len_q - 12'(s_q) - 12'd1;
    k_last   = KW'((AW'(1) << (len_q - 12'd1)) - AW'(1));
    last_k   = (k_q == k_last);
    last_s   = (12'(s_q) == len_q - 12'd1);
  end

  assign run               = (state_q == RUN);
  assign fft_busy_o        = (state_q != IDLE);
  assign fft_done_o        = (state_q == DONE);
  assign fft_error_o       = (state_q == ERROR);
  assign overflow_detect_o = ovf_q;

  assign bf.bf_valid_o   = run;
  assign bf.bf_stage_o   = run ? s_q : '0;
  assign bf.bf_addr_a_o  = run ? addr_a : '0;
  assign bf.bf_addr_b_o  = run ? addr_a + half : '0;
  assign bf.bf_tw_addr_o = run ? KW'(pos << tw_shift) : '0;
  assign bf.bf_last_o    = run && last_s && last_k;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    s_d     = s_q;
    k_d     = k_q;
    gap_d   = gap_q;
    ovf_d   = ovf_q;

    if ((state_q == RUN || state_q == GAP) && bf.dp_overflow_i) ovf_d = 1'b1;

    if (fft_reset_i) begin
      state_d = IDLE;
      s_d     = '0;
      k_d     = '0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fft_start_i) begin
            len_d   = fft_length_log2_i;
            s_d     = '0;
            k_d     = '0;
            gap_d   = '0;
            ovf_d   = 1'b0;
            state_d = CHECK;
          end
        end
        CHECK: state_d = (len_q == '0 || len_q > MAX_L) ? ERROR : RUN;
        RUN: begin
          if (bf.bf_ready_i) begin
            if (last_k) begin
              k_d     = '0;
              gap_d   = '0;
              state_d = GAP;
            end else begin
              k_d = k_q + KW'(1);
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (last_s) begin
              state_d = DONE;
            end else begin
              s_d     = s_q + SW'(1);
              state_d = RUN;
            end
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
        DONE:    state_d = IDLE;
        ERROR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      s_q     <= '0;
      k_q     <= '0;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      s_q     <= s_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fft_engine_seq.sv
// Randomized self-checking bench for fft_engine_seq against a nested-loop FFT address model.
module tb_fft_engine_seq;

  localparam int MAXL = 12;
  localparam int PD   = 4;
  localparam int NONE = 1 << 30;
  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        fft_start_i;
  logic        fft_reset_i;
  logic [11:0] fft_length_log2_i;
  logic        fft_busy_o;
  logic        fft_done_o;
  logic        fft_error_o;
  logic        overflow_detect_o;

  fft_engine_seq_if #(.FFT_MAX_LENGTH_LOG2(MAXL)) bf_if ();

  fft_engine_seq #(
    .FFT_MAX_LENGTH_LOG2(MAXL),
    .PIPE_DEPTH         (PD)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n_i),
    .fft_start_i       (fft_start_i),
    .fft_reset_i       (fft_reset_i),
    .fft_length_log2_i (fft_length_log2_i),
    .fft_busy_o        (fft_busy_o),
    .fft_done_o        (fft_done_o),
    .fft_error_o       (fft_error_o),
    .overflow_detect_o (overflow_detect_o),
    .bf                (bf_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stage;
    int a;
    int b;
    int tw;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    ovf_model = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stage s splits N points into groups of 2*half; butterfly j of group g pairs g*2h+j with +half.
  task automatic build_model(input int L);
    int n, half, span;
    exp_q.delete();
    n = 1 << L;
    for (int s = 0; s < L; s++) begin
      half = 1 << s;
      span = 2 * half;
      for (int g = 0; g < n / span; g++)
        for (int j = 0; j < half; j++)
          exp_q.push_back('{stage: s, a: g * span + j, b: g * span + j + half,
                             tw: j * (n / span),
                             last: (s == L - 1) && (g == n / span - 1) && (j == half - 1)});
    end
  endtask

  task automatic spot_check(input int L, input int idx);
    int ea, eb, et, el;
    bit hit;
    hit = 1'b1;
    ea = 0; eb = 0; et = 0; el = 0;
    if (L == 3 && idx == 0)       begin ea = 0; eb = 1; et = 0; el = 0; end
    else if (L == 3 && idx == 5)  begin ea = 1; eb = 3; et = 2; el = 0; end
    else if (L == 3 && idx == 6)  begin ea = 4; eb = 6; et = 0; el = 0; end
    else if (L == 3 && idx == 11) begin ea = 3; eb = 7; et = 3; el = 1; end
    else if (L == 1 && idx == 0)  begin ea = 0; eb = 1; et = 0; el = 1; end
    else hit = 1'b0;
    if (hit) begin
      check_val("spot_a",    bf_if.bf_addr_a_o,  ea);
      check_val("spot_b",    bf_if.bf_addr_b_o,  eb);
      check_val("spot_tw",   bf_if.bf_tw_addr_o, et);
      check_val("spot_last", bf_if.bf_last_o,    el);
    end
  endtask

  // Called at a negedge with the DUT idle; that cycle is cycle 0 (start sampled at its end).
  task automatic run_xform(input int L, input int pct, input int abort_cyc,
                           input int ovf_cyc, input int start_hold);
    bit   legal, timed, finished, aborted, prev_stall;
    int   half_n, p, t_done, t_end, beats, dones, errs, idx, total;
    logic [31:0] p_stage, p_a, p_b, p_tw;
    logic        p_last;
    beat_t e;

    legal    = (L >= 1) && (L <= MAXL);
    timed    = (pct == 100) || !legal;
    aborted  = (abort_cyc != NONE);
    half_n   = legal ? (1 << (L - 1)) : 0;
    p        = half_n + PD;
    t_done   = 2 + L * p;
    t_end    = legal ? t_done : 2;
    total    = legal ? L * half_n : 0;
    beats    = 0; dones = 0; errs = 0; idx = 0;
    finished = 1'b0;
    prev_stall = 1'b0;
    p_stage = '0; p_a = '0; p_b = '0; p_tw = '0; p_last = 1'b0;

    if (legal) build_model(L);
    else exp_q.delete();

    check_val("ovf_hold_idle", overflow_detect_o, ovf_model);
    check_val("idle_before_start", fft_busy_o, 0);
    fft_length_log2_i  = 12'(L);
    fft_start_i        = 1'b1;
    fft_reset_i        = 1'b0;
    bf_if.bf_ready_i   = 1'b0;
    bf_if.dp_overflow_i = 1'b0;

    for (int c = 1; c <= BUDGET && !finished; c++) begin
      @(negedge clk);
      if (c == 1) ovf_model = 1'b0;
      fft_start_i         = (c <= start_hold);
      fft_reset_i         = 1'b0;
      fft_length_log2_i   = 12'($urandom);
      bf_if.dp_overflow_i = 1'b0;

      if (timed && c <= abort_cyc) begin
        check_val("busy",  fft_busy_o, (c >= 1) && (c <= t_end));
        check_val("valid", bf_if.bf_valid_o,
                  legal && (c >= 2) && (c < t_done) && (((c - 2) % p) < half_n));
        check_val("done",  fft_done_o,  legal && (c == t_done));
        check_val("error", fft_error_o, !legal && (c == 2));
      end
      if (c == abort_cyc + 1) begin
        check_val("abort_busy",  fft_busy_o, 0);
        check_val("abort_valid", bf_if.bf_valid_o, 0);
        check_val("abort_done",  fft_done_o, 0);
        check_val("abort_error", fft_error_o, 0);
      end
      check_val("overflow", overflow_detect_o, ovf_model);

      if (prev_stall) begin
        check_val("stall_valid", bf_if.bf_valid_o,   1);
        check_val("stall_stage", bf_if.bf_stage_o,   p_stage);
        check_val("stall_a",     bf_if.bf_addr_a_o,  p_a);
        check_val("stall_b",     bf_if.bf_addr_b_o,  p_b);
        check_val("stall_tw",    bf_if.bf_tw_addr_o, p_tw);
        check_val("stall_last",  bf_if.bf_last_o,    p_last);
      end

      bf_if.bf_ready_i = ($urandom_range(99) < pct);
      if (c == ovf_cyc)   bf_if.dp_overflow_i = 1'b1;
      if (c == abort_cyc) fft_reset_i = 1'b1;

      if (bf_if.bf_valid_o && bf_if.bf_ready_i) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("beat_stage", bf_if.bf_stage_o,   e.stage);
          check_val("beat_a",     bf_if.bf_addr_a_o,  e.a);
          check_val("beat_b",     bf_if.bf_addr_b_o,  e.b);
          check_val("beat_tw",    bf_if.bf_tw_addr_o, e.tw);
          check_val("beat_last",  bf_if.bf_last_o,    e.last);
          spot_check(L, idx);
        end
        beats++;
        idx++;
      end
      if (fft_done_o)  dones++;
      if (fft_error_o) errs++;

      prev_stall = bf_if.bf_valid_o && !bf_if.bf_ready_i;
      p_stage = bf_if.bf_stage_o;
      p_a     = bf_if.bf_addr_a_o;
      p_b     = bf_if.bf_addr_b_o;
      p_tw    = bf_if.bf_tw_addr_o;
      p_last  = bf_if.bf_last_o;

      if (c == ovf_cyc && legal && timed && c >= 2 && c < t_done) ovf_model = 1'b1;
      if (c > 1 && !fft_busy_o) finished = 1'b1;
    end

    bf_if.bf_ready_i    = 1'b0;
    bf_if.dp_overflow_i = 1'b0;
    fft_start_i         = 1'b0;
    if (!finished) check_val("timeout", 1, 0);
    check_val("done_pulses",  dones, (legal && !aborted) ? 1 : 0);
    check_val("error_pulses", errs,  legal ? 0 : 1);
    if (!aborted) begin
      check_val("beat_count", beats, total);
      check_val("beats_left", exp_q.size(), 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_busy"},  fft_busy_o,          0);
    check_val({tag, "_done"},  fft_done_o,          0);
    check_val({tag, "_error"}, fft_error_o,         0);
    check_val({tag, "_ovf"},   overflow_detect_o,   0);
    check_val({tag, "_valid"}, bf_if.bf_valid_o,    0);
    check_val({tag, "_last"},  bf_if.bf_last_o,     0);
    check_val({tag, "_stage"}, bf_if.bf_stage_o,    0);
    check_val({tag, "_a"},     bf_if.bf_addr_a_o,   0);
    check_val({tag, "_b"},     bf_if.bf_addr_b_o,   0);
    check_val({tag, "_tw"},    bf_if.bf_tw_addr_o,  0);
  endtask

  initial begin
    reset_n_i           = 1'b0;
    fft_start_i         = 1'b0;
    fft_reset_i         = 1'b0;
    fft_length_log2_i   = '0;
    bf_if.bf_ready_i    = 1'b0;
    bf_if.dp_overflow_i = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n_i = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    // Nominal L=3, overflow pulse in the first gap, start re-asserted while busy.
    run_xform(3, 100, NONE, 7, 5);
    // Illegal lengths; the overflow pulse in ERROR must not set the flag.
    run_xform(0, 100, NONE, 2, 0);
    run_xform(13, 100, NONE, -1, 0);
    // Backpressure.
    run_xform(4, 30, NONE, -1, 0);
    // Abort in stage 1 of L=5, then immediate restart.
    run_xform(5, 100, 25, -1, 0);
    run_xform(5, 100, NONE, -1, 0);
    // Smallest transform and a few random ones.
    run_xform(1, 100, NONE, 3, 0);
    for (int i = 0; i < 4; i++)
      run_xform(int'($urandom_range(6, 1)), int'($urandom_range(100, 40)), NONE, -1, 0);

    // Asynchronous reset while issuing commands.
    fft_length_log2_i = 12'd5;
    fft_start_i       = 1'b1;
    bf_if.bf_ready_i  = 1'b1;
    @(negedge clk);
    fft_start_i = 1'b0;
    repeat (5) @(negedge clk);
    check_val("pre_areset_valid", bf_if.bf_valid_o, 1);
    #1 reset_n_i = 1'b0;
    #1 check_reset_values("areset");
    @(negedge clk);
    reset_n_i        = 1'b1;
    bf_if.bf_ready_i = 1'b0;
    @(negedge clk);
    check_reset_values("areset_release");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
